// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: write-side front end for the 32x32 register file.
// ALU writebacks own the single write port whenever they target a nonzero
// register; multiply/divide results wait in an in-order circular queue and
// retire on cycles the ALU leaves free. An ALU write squashes older queued
// MD writes to the same register so they can never overwrite newer data.
//
// MD handshake: a result transfers on a rising edge where Md_valid and
// Md_ready are both high. Md_ready depends only on registered occupancy
// (and Rst), never on Md_valid or on a pop in the same cycle. A transfer
// to $0 completes the handshake but stores nothing.
module reg_wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          Alu_valid,
  input  logic [4:0]    Alu_reg,
  input  logic [31:0]   Alu_data,
  input  logic          Md_valid,
  output logic          Md_ready,
  input  logic [4:0]    Md_reg,
  input  logic [31:0]   Md_data,
  output logic          Reg_write,
  output logic [4:0]    Write_reg,
  output logic [31:0]   Write_data,
  output logic [AW:0]   Count,
  output logic [31:0]   Pending
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [DEPTH-1:0] q_valid;
  logic [4:0]       q_reg  [DEPTH];
  logic [31:0]      q_data [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  logic alu_wr;
  logic md_hs;
  logic push;
  logic pop;

  assign Md_ready = !Rst && (count != FULL);
  assign Count    = count;

  // Arbitration: ALU to a nonzero register wins; otherwise the head pops.
  always_comb begin
    alu_wr = Alu_valid && (Alu_reg != 5'd0);
    md_hs  = Md_valid && Md_ready;
    push   = md_hs && (Md_reg != 5'd0);
    pop    = !alu_wr && (count != '0);
  end

  // Queue bookkeeping: squash first, then pop clear, then the new entry,
  // so an MD result accepted alongside a same-register ALU write survives.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      q_valid <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alu_wr && q_valid[i] && (q_reg[i] == Alu_reg)) begin
          q_valid[i] <= 1'b0;
        end
      end
      if (pop) begin
        q_valid[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + AW'(1);
      end
      if (push) begin
        q_valid[wr_ptr] <= 1'b1;
        wr_ptr          <= wr_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue payload storage; no reset needed since valid bits gate its use.
  always_ff @(posedge Clk) begin
    if (push) begin
      q_reg[wr_ptr]  <= Md_reg;
      q_data[wr_ptr] <= Md_data;
    end
  end

  // Registered write port; address/data hold when nothing is written.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Reg_write  <= 1'b0;
      Write_reg  <= 5'd0;
      Write_data <= 32'd0;
    end else if (alu_wr) begin
      Reg_write  <= 1'b1;
      Write_reg  <= Alu_reg;
      Write_data <= Alu_data;
    end else if (pop) begin
      Reg_write  <= q_valid[rd_ptr];
      Write_reg  <= q_reg[rd_ptr];
      Write_data <= q_data[rd_ptr];
    end else begin
      Reg_write  <= 1'b0;
    end
  end

  // Registers with a live queued write; $0 can never be pending.
  always_comb begin
    Pending = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_valid[i]) begin
        Pending[q_reg[i]] = 1'b1;
      end
    end
    Pending[0] = 1'b0;
  end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb_reg_wb_arbiter: directed bench with an expected-write scoreboard.
module tb_reg_wb_arbiter;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Alu_valid;
  logic [4:0]  Alu_reg;
  logic [31:0] Alu_data;
  logic        Md_valid;
  logic        Md_ready;
  logic [4:0]  Md_reg;
  logic [31:0] Md_data;
  logic        Reg_write;
  logic [4:0]  Write_reg;
  logic [31:0] Write_data;
  logic [2:0]  Count;
  logic [31:0] Pending;

  int checks   = 0;
  int failures = 0;

  logic [36:0] exp_q[$];
  logic [36:0] mdq[$];

  reg_wb_arbiter #(.DEPTH(4), .AW(2)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Alu_valid  (Alu_valid),
    .Alu_reg    (Alu_reg),
    .Alu_data   (Alu_data),
    .Md_valid   (Md_valid),
    .Md_ready   (Md_ready),
    .Md_reg     (Md_reg),
    .Md_data    (Md_data),
    .Reg_write  (Reg_write),
    .Write_reg  (Write_reg),
    .Write_data (Write_data),
    .Count      (Count),
    .Pending    (Pending)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  // driver tasks
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic expect_wr(input logic [4:0] r, input logic [31:0] d);
    exp_q.push_back({r, d});
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: every register-file write must match the queue head
  always @(negedge Clk) begin
    logic [36:0] e;
    if (Reg_write === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: got reg=%0d data=%h, no write expected",
                 Write_reg, Write_data);
      end else begin
        e = exp_q.pop_front();
        if ({Write_reg, Write_data} !== e) begin
          failures++;
          $display("FAIL wb_write: got reg=%0d data=%h expected reg=%0d data=%h",
                   Write_reg, Write_data, e[36:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    Rst = 1'b1; Alu_valid = 1'b0; Alu_reg = '0; Alu_data = '0;
    Md_valid = 1'b0; Md_reg = '0; Md_data = '0;

    // reset state
    step(); step();
    chk("rst_reg_write", Reg_write, 0);
    chk("rst_write_reg", Write_reg, 0);
    chk("rst_write_data", Write_data, 0);
    chk("rst_count", Count, 0);
    chk("rst_pending", Pending, 0);
    chk("rst_md_ready", Md_ready, 0);
    Rst = 1'b0;
    #1;
    chk("rel_md_ready", Md_ready, 1);

    // ALU path
    Alu_valid = 1'b1; Alu_reg = 5'd5; Alu_data = 32'h0000_1234;
    expect_wr(5'd5, 32'h0000_1234);
    step();
    chk("alu_reg_write", Reg_write, 1);
    chk("alu_write_reg", Write_reg, 5);
    chk("alu_write_data", Write_data, 32'h1234);
    Alu_valid = 1'b0;
    step();
    chk("alu_idle", Reg_write, 0);

    // fill while ALU busy on $1, then drain
    Alu_valid = 1'b1; Alu_reg = 5'd1;
    for (int k = 0; k < 5; k++) begin
      Alu_data = 32'(32'h100 + k);
      Md_valid = 1'b1; Md_reg = 5'(2 + k); Md_data = 32'(32'hA2 + k);
      chk("fill_ready", Md_ready, (k < 4) ? 1 : 0);
      expect_wr(5'd1, 32'(32'h100 + k));
      step();
    end
    chk("full_count", Count, 4);
    chk("full_ready", Md_ready, 0);
    chk("full_pending", Pending, 32'h0000_003C);
    Alu_valid = 1'b0;
    expect_wr(5'd2, 32'hA2);
    step();
    chk("drain_count1", Count, 3);
    expect_wr(5'd3, 32'hA3);
    step();
    chk("drain_reaccept_count", Count, 3);
    Md_valid = 1'b0;
    expect_wr(5'd4, 32'hA4); step();
    expect_wr(5'd5, 32'hA5); step();
    expect_wr(5'd6, 32'hA6); step();
    chk("drain_empty", Count, 0);
    step();
    chk("drain_idle", Reg_write, 0);

    // $0 handling
    Md_valid = 1'b1; Md_reg = 5'd9; Md_data = 32'h99;
    step();
    chk("z_queued", Count, 1);
    chk("z_pending9", Pending, 32'h0000_0200);
    Md_valid = 1'b0;
    Alu_valid = 1'b1; Alu_reg = 5'd0; Alu_data = 32'hDEAD;
    expect_wr(5'd9, 32'h99);
    step();
    chk("z_alu0_pops", Count, 0);
    chk("z_alu0_reg", Write_reg, 9);
    Alu_valid = 1'b0;
    Md_valid = 1'b1; Md_reg = 5'd0; Md_data = 32'h55;
    chk("z_md0_ready", Md_ready, 1);
    step();
    chk("z_md0_count", Count, 0);
    chk("z_md0_pending", Pending, 0);
    Md_valid = 1'b0;
    step(); step();
    chk("z_md0_nowrite", Reg_write, 0);

    // squash
    Alu_valid = 1'b1; Alu_reg = 5'd1; Alu_data = 32'h77;
    Md_valid = 1'b1; Md_reg = 5'd8; Md_data = 32'h0000_AAAA;
    expect_wr(5'd1, 32'h77);
    step();
    chk("sq_pending8", Pending, 32'h0000_0100);
    Md_valid = 1'b0;
    Alu_reg = 5'd8; Alu_data = 32'h0000_BBBB;
    expect_wr(5'd8, 32'h0000_BBBB);
    step();
    chk("sq_pending_clear", Pending, 0);
    chk("sq_count_kept", Count, 1);
    chk("sq_alu_data", Write_data, 32'hBBBB);
    Alu_valid = 1'b0;
    step();
    chk("sq_pop_nowrite", Reg_write, 0);
    chk("sq_pop_count", Count, 0);

    // same-cycle ALU and MD to one register: MD is younger and survives
    Alu_valid = 1'b1; Alu_reg = 5'd10; Alu_data = 32'hC1;
    Md_valid = 1'b1; Md_reg = 5'd10; Md_data = 32'hC2;
    expect_wr(5'd10, 32'hC1);
    step();
    chk("same_pending10", Pending, 32'h0000_0400);
    Alu_valid = 1'b0; Md_valid = 1'b0;
    expect_wr(5'd10, 32'hC2);
    step();
    chk("same_drained", Count, 0);

    // simultaneous push/pop at Count=3 across pointer wrap
    Alu_valid = 1'b1; Alu_reg = 5'd1;
    for (int k = 0; k < 3; k++) begin
      Alu_data = 32'(32'h200 + k);
      Md_valid = 1'b1; Md_reg = 5'(11 + k); Md_data = 32'(32'hB0 + k);
      mdq.push_back({Md_reg, Md_data});
      expect_wr(5'd1, 32'(32'h200 + k));
      step();
    end
    chk("pp_count3", Count, 3);
    Alu_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      Md_reg = 5'(14 + k); Md_data = 32'(32'hB3 + k);
      exp_q.push_back(mdq.pop_front());
      mdq.push_back({Md_reg, Md_data});
      step();
      chk("pp_count_hold", Count, 3);
    end
    Md_valid = 1'b0;
    chk("pp_pending", Pending, 32'h0038_0000);
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(mdq.pop_front());
      step();
    end
    chk("pp_drained", Count, 0);

    // reset mid-operation with inputs active
    Alu_valid = 1'b1; Alu_reg = 5'd1;
    for (int k = 0; k < 3; k++) begin
      Alu_data = 32'(32'h300 + k);
      Md_valid = 1'b1; Md_reg = 5'(2 + k); Md_data = 32'(32'hD0 + k);
      expect_wr(5'd1, 32'(32'h300 + k));
      step();
    end
    chk("mid_count3", Count, 3);
    Rst = 1'b1; Md_reg = 5'd7;
    #1;
    chk("mid_rst_ready", Md_ready, 0);
    for (int k = 0; k < 2; k++) begin
      step();
      chk("mid_rst_reg_write", Reg_write, 0);
      chk("mid_rst_write_reg", Write_reg, 0);
      chk("mid_rst_write_data", Write_data, 0);
      chk("mid_rst_count", Count, 0);
      chk("mid_rst_pending", Pending, 0);
      chk("mid_rst_md_ready", Md_ready, 0);
    end
    Rst = 1'b0; Alu_valid = 1'b0; Md_valid = 1'b0;
    #1;
    chk("mid_rel_ready", Md_ready, 1);
    for (int k = 0; k < 4; k++) step();
    chk("mid_no_stale", Reg_write, 0);
    chk("mid_count_after", Count, 0);

    chk("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
